// File: rtl/fetch_pipe_ctrl.sv
// Fetch-stage controller: owns the program counter, drives the instruction
// ROM address and loads the IF/ID pipeline register. It handles stall, flush
// and execute-stage redirects. A fetch outside the ROM window parks the core
// in FAULT until reset.
module fetch_pipe_ctrl #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = 32'hBFC00000,
  parameter logic [ADDRESS_WIDTH-1:0] ROM_BASE      = 32'hBFC00000,
  parameter int                       ROM_BYTES     = 4096,
  parameter logic [31:0]              NOP_INSTR     = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              instr_f,
  input  logic                     stall_f,
  input  logic                     flush_d,
  input  logic                     pc_src_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
  output logic [ADDRESS_WIDTH-1:0] pc_f,
  output logic [31:0]              instr_d,
  output logic [ADDRESS_WIDTH-1:0] pc_d,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
  output logic                     valid_d,
  output logic                     fetch_fault,
  output logic [31:0]              fetch_count
);

  typedef enum logic {RUN, FAULT} state_t;

  // Address of the last whole word inside the ROM window.
  localparam logic [ADDRESS_WIDTH-1:0] ROM_LAST =
    ROM_BASE + ADDRESS_WIDTH'(ROM_BYTES - 4);

  state_t                     state, state_next;
  logic [ADDRESS_WIDTH-1:0]   pc_next, pc_d_next, pc_plus4_d_next, pc_plus4;
  logic [31:0]                instr_next, count_next;
  logic                       valid_next, fault_next, pc_legal;

  // The ROM is combinational, so legality depends only on the registered PC.
  assign pc_legal = (pc_f[1:0] == 2'b00) && (pc_f >= ROM_BASE) && (pc_f <= ROM_LAST);
  assign pc_plus4 = pc_f + ADDRESS_WIDTH'(4);

  // Next-state and next-register selection in priority order.
  always_comb begin
    // NOTE: every target is given a hold value first. Any path that skips an
    // assignment then keeps the register value and does not infer a latch.
    state_next      = state;
    pc_next         = pc_f;
    instr_next      = instr_d;
    pc_d_next       = pc_d;
    pc_plus4_d_next = pc_plus4_d;
    valid_next      = valid_d;
    fault_next      = fetch_fault;
    count_next      = fetch_count;

    case (state)
      RUN: begin
        if (pc_src_e) begin
          // Redirect beats stall and flush. The target is checked on the
          // following edge, like any other fetch address.
          pc_next    = pc_target_e;
          instr_next = NOP_INSTR;
          valid_next = 1'b0;
        end else if (stall_f) begin
          // Hold everything. A flush during a stall is deliberately dropped.
        end else if (!pc_legal) begin
          state_next = FAULT;
          fault_next = 1'b1;
          instr_next = NOP_INSTR;
          valid_next = 1'b0;
        end else if (flush_d) begin
          instr_next = NOP_INSTR;
          valid_next = 1'b0;
          pc_next    = pc_plus4;
        end else begin
          instr_next      = instr_f;
          pc_d_next       = pc_f;
          pc_plus4_d_next = pc_plus4;
          valid_next      = 1'b1;
          pc_next         = pc_plus4;
          count_next      = fetch_count + 32'd1;
        end
      end
      FAULT: begin
        // Parked: every input except rst is ignored.
      end
      default: state_next = FAULT;
    endcase
  end

  // State and pipeline registers, with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments. Every register
    // then samples values from before the edge, whatever the statement order.
    if (rst) begin
      state       <= RUN;
      pc_f        <= RESET_VECTOR;
      instr_d     <= NOP_INSTR;
      pc_d        <= '0;
      pc_plus4_d  <= '0;
      valid_d     <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_next;
      pc_f        <= pc_next;
      instr_d     <= instr_next;
      pc_d        <= pc_d_next;
      pc_plus4_d  <= pc_plus4_d_next;
      valid_d     <= valid_next;
      fetch_fault <= fault_next;
      fetch_count <= count_next;
    end
  end

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Self-checking bench for fetch_pipe_ctrl. The bench first runs directed
// steps from the test plan, then a randomized run. Each step drives the
// inputs, lets one rising edge pass and compares every output with a
// behavioural model of the fetch rules.
module tb_fetch_pipe_ctrl;

  localparam logic [31:0] BASE = 32'hBFC00000;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, stall_f, flush_d, pc_src_e;
  logic [31:0] instr_f, pc_target_e;
  logic [31:0] pc_f, instr_d, pc_d, pc_plus4_d, fetch_count;
  logic        valid_d, fetch_fault;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4d, m_cnt;
  logic        m_valid, m_fault;

  fetch_pipe_ctrl dut (
    .clk(clk), .rst(rst), .instr_f(instr_f), .stall_f(stall_f),
    .flush_d(flush_d), .pc_src_e(pc_src_e), .pc_target_e(pc_target_e),
    .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // ROM contents: a scrambled function of the address, so that each word
  // is distinct.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  assign instr_f = rom_word(pc_f);

  function automatic bit in_rom(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return (a % 4 == 0) && (off < 32'd4096);
  endfunction

  // Apply one edge's worth of behaviour to the model.
  task automatic model_edge(input logic r, st, fl, src, input logic [31:0] tgt);
    if (r) begin
      m_pc = BASE; m_instr = NOP; m_pcd = 0; m_pc4d = 0;
      m_valid = 0; m_fault = 0; m_cnt = 0;
    end else if (m_fault) begin
      // Parked until reset.
    end else if (src) begin
      m_pc = tgt; m_instr = NOP; m_valid = 0;
    end else if (st) begin
      // Hold.
    end else if (!in_rom(m_pc)) begin
      m_fault = 1; m_instr = NOP; m_valid = 0;
    end else if (fl) begin
      m_instr = NOP; m_valid = 0; m_pc = m_pc + 4;
    end else begin
      m_instr = rom_word(m_pc); m_pcd = m_pc; m_pc4d = m_pc + 4;
      m_valid = 1; m_pc = m_pc + 4; m_cnt = m_cnt + 1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    check({ctx, ".pc_f"},        pc_f,                m_pc);
    check({ctx, ".instr_d"},     instr_d,             m_instr);
    check({ctx, ".pc_d"},        pc_d,                m_pcd);
    check({ctx, ".pc_plus4_d"},  pc_plus4_d,          m_pc4d);
    check({ctx, ".valid_d"},     {31'b0, valid_d},    {31'b0, m_valid});
    check({ctx, ".fetch_fault"}, {31'b0, fetch_fault}, {31'b0, m_fault});
    check({ctx, ".fetch_count"}, fetch_count,         m_cnt);
  endtask

  // Drive inputs away from the edge, advance one edge and compare at edge+1.
  task automatic step(input string ctx, input logic r, st, fl, src,
                      input logic [31:0] tgt);
    @(negedge clk);
    rst = r; stall_f = st; flush_d = fl; pc_src_e = src; pc_target_e = tgt;
    model_edge(r, st, fl, src, tgt);
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  initial begin
    logic [31:0] tgt, cnt_at_fault;
    int r;
    rst = 1; stall_f = 0; flush_d = 0; pc_src_e = 0; pc_target_e = 0;

    // Reset values.
    step("reset", 1, 0, 0, 0, 0);
    check("reset.pc_const", pc_f, 32'hBFC00000);

    // Four free-running fetches.
    for (int i = 0; i < 4; i++) step("run", 0, 0, 0, 0, 0);
    check("run4.pc_const", pc_f, 32'hBFC00010);
    check("run4.count_const", fetch_count, 32'd4);
    check("run4.instr_w3", instr_d, rom_word(32'hBFC0000C));

    // Stall for three cycles at 0x...08, with a flush pulse in the middle.
    step("reset2", 1, 0, 0, 0, 0);
    step("run", 0, 0, 0, 0, 0);
    step("run", 0, 0, 0, 0, 0);
    check("stall.pc_at", pc_f, 32'hBFC00008);
    step("stall", 0, 1, 0, 0, 0);
    step("stall_flush", 0, 1, 1, 0, 0);
    step("stall", 0, 1, 0, 0, 0);
    check("stall.count_frozen", fetch_count, 32'd2);
    step("resume", 0, 0, 0, 0, 0);
    check("resume.pc_d", pc_d, 32'hBFC00008);

    // A redirect takes priority over a stall and a flush on the same edge.
    step("redir", 0, 1, 1, 1, 32'hBFC00100);
    check("redir.pc_const", pc_f, 32'hBFC00100);
    check("redir.instr_nop", instr_d, NOP);
    step("redir_next", 0, 0, 0, 0, 0);
    check("redir_next.pc_d", pc_d, 32'hBFC00100);

    // A misaligned redirect faults on the following edge and stays parked.
    step("bad_redir", 0, 0, 0, 1, 32'hBFC00102);
    step("fault", 0, 0, 0, 0, 0);
    check("fault.flag", {31'b0, fetch_fault}, 32'd1);
    step("fault_ignore", 0, 0, 0, 1, 32'hBFC00200);
    check("fault_ignore.pc", pc_f, 32'hBFC00102);
    step("fault_rst", 1, 0, 0, 0, 0);

    // The end of the window: the last word fetches and the next PC faults.
    step("to_end", 0, 0, 0, 1, 32'hBFC00FF0);
    for (int i = 0; i < 4; i++) step("end_run", 0, 0, 0, 0, 0);
    check("end.last_pc_d", pc_d, 32'hBFC00FFC);
    check("end.pc_over", pc_f, 32'hBFC01000);
    cnt_at_fault = fetch_count;
    step("end_fault", 0, 0, 0, 0, 0);
    step("end_hold", 0, 0, 0, 0, 0);
    check("end.count_held", fetch_count, cnt_at_fault);

    // Reset mid-run while stalled.
    step("rst3", 1, 0, 0, 0, 0);
    step("to40", 0, 0, 0, 1, 32'hBFC00040);
    step("run40", 0, 0, 0, 0, 0);
    step("rst_stall", 1, 1, 0, 0, 0);

    // Randomized run: mostly legal traffic, with occasional illegal redirects
    // and resets.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8)       tgt = BASE + ($urandom_range(0, 1023) << 2);
      else if (r < 10) tgt = BASE + 32'hFF0 + ($urandom_range(0, 3) << 2);
      else if (r < 11) tgt = $urandom;
      else             tgt = 32'h0;
      step("rand", ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 25),
           ($urandom_range(0, 99) < 20), (r < 11), tgt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_pipe_ctrl.md
Name: fetch_pipe_ctrl

Overview:
Fetch-stage controller that sits directly upstream of the instruction ROM and feeds the decode stage. It owns the program counter and drives the ROM byte address. It latches the ROM's little-endian 32-bit word into the IF/ID pipeline register, handling stall, flush and branch/jump redirect. It also detects fetches outside the ROM window (0xBFC00000–0xBFC00FFF) and parks the core in a fault state.

Parameters:
ADDRESS_WIDTH, 32, PC/address width
RESET_VECTOR, 32'hBFC00000, PC value after reset
ROM_BASE, 32'hBFC00000, lowest valid fetch byte address
ROM_BYTES, 4096, ROM size in bytes; last valid word address = ROM_BASE+ROM_BYTES-4
NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
instr_f  input  32  word returned combinationally by instruction ROM for pc_f
stall_f  input  1  hazard unit: hold PC and IF/ID
flush_d  input  1  hazard unit: replace IF/ID contents with bubble
pc_src_e  input  1  execute stage: redirect taken
pc_target_e  input  32  redirect target byte address
pc_f  output  32  current fetch address, drives ROM addr
instr_d  output  32  IF/ID instruction
pc_d  output  32  IF/ID PC of instr_d
pc_plus4_d  output  32  IF/ID pc_d+4
valid_d  output  1  IF/ID holds a real instruction
fetch_fault  output  1  sticky: illegal fetch address detected
fetch_count  output  32  number of instructions latched with valid_d=1

Behaviour:
- Reset (rst=1 at edge, any state): pc_f=RESET_VECTOR, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, valid_d=0, fetch_fault=0, fetch_count=0, state=RUN. Reset overrides all other inputs.
- pc_legal = (pc_f[1:0]==0) && pc_f>=ROM_BASE && pc_f<=ROM_BASE+ROM_BYTES-4. Comparisons are unsigned 32-bit. All PC adds are mod 2^32.
- ROM is combinational, so instr_f for pc_f is latched at the same edge. Fetch-to-decode latency is 1 cycle.
- States: RUN, FAULT.
- RUN, per edge, priority order:
  1. pc_src_e=1:
     - pc_f<=pc_target_e.
     - IF/ID<=bubble (instr_d=NOP_INSTR, valid_d=0; pc_d/pc_plus4_d hold).
     - Redirect wins over stall_f and flush_d.
  2. stall_f=1: pc_f and IF/ID hold. flush_d is ignored while stalled.
  3. pc_legal=0:
     - go to FAULT, fetch_fault<=1.
     - IF/ID<=bubble, pc_f holds.
  4. flush_d=1: IF/ID<=bubble, pc_f<=pc_f+4.
  5. else:
     - instr_d<=instr_f, pc_d<=pc_f, pc_plus4_d<=pc_f+4, valid_d<=1.
     - pc_f<=pc_f+4, fetch_count<=fetch_count+1.
- A redirect to an illegal target is accepted. The fault is raised on the following edge, via rule 3, unless stall_f is high or another redirect arrives.
- FAULT: pc_f, IF/ID (bubble) and fetch_count hold. All inputs ignored; only rst exits.
- fetch_count wraps 0xFFFFFFFF->0.
- Last valid word 0xBFC00FFC fetches normally. The next PC 0xBFC01000 faults one cycle later.
- Outputs are registered only. pc_f is a register output, so the ROM address has no combinational path from the inputs.

Test Plan:
- Reset then 4 free-run cycles, ROM words W0..W3 -> pc_f 0xBFC00000,…04,…08,…0C,…10; pc_d lags pc_f by one edge; instr_d=W0..W3 in turn; valid_d=1 from cycle 1; fetch_count=4.
- stall_f high for 3 cycles at pc_f=0xBFC00008 -> pc_f, instr_d and fetch_count frozen; flush_d pulsed during the stall has no effect; normal fetch resumes from 0xBFC00008.
- pc_src_e=1, pc_target_e=0xBFC00100, with stall_f=1 and flush_d=1 on the same edge -> next pc_f=0xBFC00100, instr_d=0x00000013, valid_d=0; next edge latches word at 0x100 with pc_d=0xBFC00100.
- Redirect to 0xBFC00102 -> one cycle later fetch_fault=1, pc_f stays 0xBFC00102, valid_d=0; further pc_src_e ignored; rst clears to 0xBFC00000 and fetch_fault=0.
- Run to pc_f=0xBFC00FFC -> that word latched valid; pc_f=0xBFC01000, then fault on the next edge; fetch_count unchanged after the fault.
- Assert rst mid-run at pc_f=0xBFC00040 with stall_f=1 -> all outputs at reset values on the next edge.
